// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic drain stage.
package systolic_pkg;

   // Widest block index a tile buffer can hold; ports narrower than this are zero-extended.
   localparam int unsigned BLK_MAX_W = 16;

   // clog2 that never returns zero, so single-entry ranges still get a 1-bit field.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   function automatic int unsigned calc_row_blk_w(input int unsigned m, input int unsigned n1);
      return clog2_min1(m / n1);
   endfunction

   function automatic int unsigned calc_col_blk_w(input int unsigned m, input int unsigned n2);
      return clog2_min1(m / n2);
   endfunction

   function automatic int unsigned calc_addr_w(input int unsigned m, input int unsigned n2);
      return clog2_min1((m * m) / n2);
   endfunction

   typedef enum logic [0:0] {
      StIdle,
      StDrain
   } drain_state_e;

   // Bookkeeping held next to each buffered tile.
   typedef struct packed {
      logic                 full;
      logic [BLK_MAX_W-1:0] row_blk;
      logic [BLK_MAX_W-1:0] col_blk;
   } tile_meta_t;

endpackage

// File: rtl/systolic_drain_buf.sv
// One ping/pong tile buffer: stores a tile plus its block indices and a full flag.
module systolic_drain_buf
   import systolic_pkg::*;
#(
   parameter int unsigned TILE_W = 512
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 free,
   input  logic [TILE_W-1:0]    load_data,
   input  logic [BLK_MAX_W-1:0] load_row_blk,
   input  logic [BLK_MAX_W-1:0] load_col_blk,
   output tile_meta_t           meta,
   output logic [TILE_W-1:0]    data,
   output logic                 full_nxt
);

   tile_meta_t          meta_q, meta_d;
   logic [TILE_W-1:0]   data_q, data_d;

   // Next contents: a load in the same cycle as a free wins, so the buffer stays full.
   always_comb begin
      meta_d = meta_q;
      data_d = data_q;
      if (free) begin
         meta_d.full = 1'b0;
      end
      if (load) begin
         meta_d.full    = 1'b1;
         meta_d.row_blk = load_row_blk;
         meta_d.col_blk = load_col_blk;
         data_d         = load_data;
      end
   end

   // Meta (including the full flag) resets; tile data is only read while full.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
      end else begin
         meta_q <= meta_d;
      end
      data_q <= data_d;
   end

   assign meta     = meta_q;
   assign data     = data_q;
   assign full_nxt = meta_d.full;

endmodule

// File: rtl/systolic_drain.sv
// Drains finished N1 x N2 accumulator tiles row-by-row into C memory via two tile buffers.
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int unsigned D_W_ACC = 16,
   parameter int unsigned N1      = 4,
   parameter int unsigned N2      = 8,
   parameter int unsigned M       = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 tile_valid,
   input  logic [N1*N2*D_W_ACC-1:0]             tile_data,
   input  logic [calc_row_blk_w(M, N1)-1:0]     tile_row_blk,
   input  logic [calc_col_blk_w(M, N2)-1:0]     tile_col_blk,
   output logic                                 wr_en,
   output logic [calc_addr_w(M, N2)-1:0]        wr_addr,
   output logic [N2*D_W_ACC-1:0]                wr_data,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 overflow
);

   localparam int unsigned ADDR_W    = calc_addr_w(M, N2);
   localparam int unsigned TILE_W    = N1 * N2 * D_W_ACC;
   localparam int unsigned WORD_W    = N2 * D_W_ACC;
   localparam int unsigned RCNT_W    = clog2_min1(N1);
   localparam int unsigned NUM_TILES = (M / N1) * (M / N2);
   localparam int unsigned TCNT_W    = clog2_min1(NUM_TILES);

   // Drain FSM and counters
   drain_state_e        state_q, state_d;
   logic [RCNT_W-1:0]   row_q, row_d;
   logic [TCNT_W-1:0]   tile_cnt_q, tile_cnt_d;
   logic                rptr_q, rptr_d;
   logic                wptr_q, wptr_d;
   logic                done_pend_q, done_pend_d;
   logic                ovf_q, ovf_d;

   // Registered outputs
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [WORD_W-1:0]   wr_data_q, wr_data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // Buffer interface
   logic [1:0]          buf_load;
   logic [1:0]          buf_free;
   logic [1:0]          buf_full_nxt;
   tile_meta_t          buf_meta [2];
   logic [TILE_W-1:0]   buf_data [2];
   logic [BLK_MAX_W-1:0] in_row_blk, in_col_blk;

   // Capture / drain handshake
   logic                drain_last;
   logic                wr_buf_busy;
   logic                cap_ok;
   logic                cap_to_rd;
   logic                rd_full;
   logic                other_full;
   logic                emit;
   logic                bypass;

   // Selected drain source
   logic [TILE_W-1:0]    src_data;
   logic [BLK_MAX_W-1:0] src_row_blk;
   logic [BLK_MAX_W-1:0] src_col_blk;

   assign in_row_blk = BLK_MAX_W'(tile_row_blk);
   assign in_col_blk = BLK_MAX_W'(tile_col_blk);

   for (genvar i = 0; i < 2; i++) begin : g_buf
      systolic_drain_buf #(
         .TILE_W (TILE_W)
      ) u_buf (
         .clk          (clk),
         .rst          (rst),
         .load         (buf_load[i]),
         .free         (buf_free[i]),
         .load_data    (tile_data),
         .load_row_blk (in_row_blk),
         .load_col_blk (in_col_blk),
         .meta         (buf_meta[i]),
         .data         (buf_data[i]),
         .full_nxt     (buf_full_nxt[i])
      );
   end

   // Last row of the read buffer is being emitted; kept outside the FSM block to avoid a loop
   // through the capture logic.
   assign drain_last = (state_q == StDrain) && (row_q == RCNT_W'(N1 - 1));
   assign rd_full    = buf_meta[rptr_q].full;
   assign other_full = buf_meta[~rptr_q].full;

   // Capture into the write-pointer buffer; a buffer being freed this cycle can be reloaded.
   always_comb begin
      buf_free         = '0;
      buf_free[rptr_q] = drain_last;
      wr_buf_busy      = buf_meta[wptr_q].full && !buf_free[wptr_q];
      cap_ok           = tile_valid && !wr_buf_busy;
      cap_to_rd        = cap_ok && (wptr_q == rptr_q);
      buf_load         = '0;
      buf_load[wptr_q] = cap_ok;
      wptr_d           = wptr_q ^ cap_ok;
      ovf_d            = ovf_q | (tile_valid & wr_buf_busy);
   end

   // Drain FSM: start on a full (or just-captured) read buffer, one row per cycle.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      rptr_d      = rptr_q;
      tile_cnt_d  = tile_cnt_q;
      done_pend_d = 1'b0;
      emit        = 1'b0;
      bypass      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rd_full || cap_to_rd) begin
               // A tile captured this cycle is not in the buffer yet, so take row 0 from the port.
               emit    = 1'b1;
               bypass  = !rd_full;
               row_d   = RCNT_W'(1);
               state_d = StDrain;
            end
         end
         StDrain: begin
            emit = 1'b1;
            if (drain_last) begin
               row_d       = '0;
               rptr_d      = ~rptr_q;
               done_pend_d = (tile_cnt_q == TCNT_W'(NUM_TILES - 1));
               tile_cnt_d  = done_pend_d ? '0 : tile_cnt_q + TCNT_W'(1);
               // Continue straight into the other buffer when it already holds a tile.
               state_d     = other_full ? StDrain : StIdle;
            end else begin
               row_d = row_q + RCNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Drain source: either the read buffer or the incoming tile on its capture cycle.
   always_comb begin
      src_data    = buf_data[rptr_q];
      src_row_blk = buf_meta[rptr_q].row_blk;
      src_col_blk = buf_meta[rptr_q].col_blk;
      if (bypass) begin
         src_data    = tile_data;
         src_row_blk = in_row_blk;
         src_col_blk = in_col_blk;
      end
   end

   // Output next-state; address and data hold while no row is emitted.
   always_comb begin
      wr_en_d   = emit;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (emit) begin
         // Wide arithmetic then truncation gives the same result as ADDR_W-wide math.
         wr_addr_d = ADDR_W'((32'(src_row_blk) * N1 + 32'(row_q)) * (M / N2)
                             + 32'(src_col_blk));
         wr_data_d = src_data[WORD_W * int'(row_q) +: WORD_W];
      end
      busy_d = buf_full_nxt[0] | buf_full_nxt[1] | emit | (state_d == StDrain);
      done_d = done_pend_q;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         row_q       <= '0;
         tile_cnt_q  <= '0;
         rptr_q      <= 1'b0;
         wptr_q      <= 1'b0;
         done_pend_q <= 1'b0;
         ovf_q       <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         tile_cnt_q  <= tile_cnt_d;
         rptr_q      <= rptr_d;
         wptr_q      <= wptr_d;
         done_pend_q <= done_pend_d;
         ovf_q       <= ovf_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;

endmodule
